// File: rtl/audio_sample_streamer_pkg.sv
// audio_sample_streamer_pkg: shared widths, rate defaults, FSM states and the attenuation helper
package audio_sample_streamer_pkg;

    localparam int CLK_HZ_DEF    = 50_000_000;
    localparam int SAMPLE_HZ_DEF = 48_000;
    localparam int SAMPLE_W      = 32;
    localparam int VOL_W         = 4;

    typedef enum logic [1:0] {ST_IDLE, ST_CAPTURE, ST_SCALE, ST_PUSH} state_t;

    // Volume 15 is unity gain; each step below halves the sample, 0 mutes
    function automatic logic [SAMPLE_W-1:0] attenuate(input logic signed [SAMPLE_W-1:0] x,
                                                      input logic [VOL_W-1:0] vol);
        return (vol == '0) ? '0 : x >>> (4'd15 - vol);
    endfunction

endpackage

// File: rtl/audio_sample_streamer_sync_fifo.sv
// audio_sample_streamer_sync_fifo: small power-of-two FIFO; a pop in the same cycle frees a slot for a push to a full FIFO
module audio_sample_streamer_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    // Occupancy flags from the wrap bit, pointer advance and head read
    always_comb begin
        empty    = wr_ptr_q == rd_ptr_q;
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
        dout     = mem_q[rd_ptr_q[AW-1:0]];
    end

    // Pointer registers; reset discards every queued entry
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array needs no reset since the pointers gate every read
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/audio_sample_streamer.sv
// audio_sample_streamer: decimates a wave sample to the codec rate, attenuates it and streams it to the codec (optional DC blocker: STREAMER_DC_BLOCK_EN)
module audio_sample_streamer
    import audio_sample_streamer_pkg::*;
#(
    parameter int CLK_HZ     = CLK_HZ_DEF,
    parameter int SAMPLE_HZ  = SAMPLE_HZ_DEF,
    parameter int FIFO_DEPTH = 4
`ifdef STREAMER_DC_BLOCK_EN
    , parameter int DC_SHIFT = 10
`endif
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [SAMPLE_W-1:0] sample_in,
    input  logic [VOL_W-1:0]    volume,
    input  logic                audio_out_allowed,
    output logic                write_audio_out,
    output logic [SAMPLE_W-1:0] left_channel_audio_out,
    output logic [SAMPLE_W-1:0] right_channel_audio_out,
    output logic                overflow,
    input  logic                clr_overflow
);

    localparam int DIV = CLK_HZ / SAMPLE_HZ;
    localparam int CW  = $clog2(DIV);

    logic [CW-1:0]              cnt_q, cnt_d;
    logic                       tick;
    state_t                     state_q, state_d;
    logic signed [SAMPLE_W-1:0] s_q, s_d, x_new;
    logic [SAMPLE_W-1:0]        last_q, last_d, head, y;
    logic                       ovf_q, ovf_d;
    logic                       push, drop, pop, full, empty, capture;
`ifdef STREAMER_DC_BLOCK_EN
    logic signed [SAMPLE_W-1:0] xp_q, xp_d, dp_q, dp_d, d_new;
`endif

    // Sample-rate divider: one-cycle tick on the last count, then wrap
    always_comb begin
        tick  = cnt_q == CW'(DIV - 1);
        cnt_d = tick ? '0 : cnt_q + CW'(1);
    end

    // Frame sequencer; a tick outside IDLE is impossible for DIV>=4 and is ignored
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    state_d = tick ? ST_CAPTURE : ST_IDLE;
            ST_CAPTURE: state_d = ST_SCALE;
            ST_SCALE:   state_d = ST_PUSH;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Capture, attenuate, queue with drop-on-full, and drain to the codec
    always_comb begin
        capture = state_q == ST_CAPTURE;
        x_new   = $signed(sample_in >> 1);
`ifdef STREAMER_DC_BLOCK_EN
        d_new   = x_new - xp_q + dp_q - (dp_q >>> DC_SHIFT);
        xp_d    = capture ? x_new : xp_q;
        dp_d    = capture ? d_new : dp_q;
        s_d     = capture ? d_new : s_q;
`else
        s_d     = capture ? x_new : s_q;
`endif
        y       = attenuate(s_q, volume);
        pop     = !empty && audio_out_allowed;
        push    = (state_q == ST_SCALE) && (!full || pop);
        drop    = (state_q == ST_SCALE) && full && !pop;
        ovf_d   = drop || (ovf_q && !clr_overflow);
        last_d  = pop ? head : last_q;
        write_audio_out         = pop;
        left_channel_audio_out  = pop ? head : last_q;
        right_channel_audio_out = pop ? head : last_q;
        overflow                = ovf_q;
    end

    // State, sample and status registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q   <= '0;
            state_q <= ST_IDLE;
            s_q     <= '0;
            last_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            state_q <= state_d;
            s_q     <= s_d;
            last_q  <= last_d;
            ovf_q   <= ovf_d;
        end
    end

`ifdef STREAMER_DC_BLOCK_EN
    // DC-blocker history, advanced once per captured sample
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            xp_q <= '0;
            dp_q <= '0;
        end else begin
            xp_q <= xp_d;
            dp_q <= dp_d;
        end
    end
`endif

    audio_sample_streamer_sync_fifo #(
        .WIDTH(SAMPLE_W),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .reset_n(reset_n),
        .push   (push),
        .pop    (pop),
        .din    (y),
        .dout   (head),
        .full   (full),
        .empty  (empty)
    );

endmodule

// File: tb/tb_audio_sample_streamer.sv
// tb_audio_sample_streamer: randomized bench against a queue-based reference model (default build)
module tb_audio_sample_streamer;

    localparam int DIV   = 1041;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] sample_in = 32'h0000_0200;
    logic [3:0]  volume = 4'd15;
    logic        audio_out_allowed = 1'b0;
    logic        clr_overflow = 1'b0;
    logic        write_audio_out, overflow;
    logic [31:0] left_channel_audio_out, right_channel_audio_out;

    int          n_checks = 0;
    int          n_pass = 0;
    int          cyc = 0;
    int          mode = 0;
    int          first_seen = -1;
    bit          run1 = 1'b1;
    bit          exp_w;
    bit          ov_exp = 1'b0;
    logic [31:0] last_exp = '0;
    logic [31:0] mq[$];

    always #5 clk = ~clk;

    audio_sample_streamer dut (
        .clk                    (clk),
        .reset_n                (reset_n),
        .sample_in              (sample_in),
        .volume                 (volume),
        .audio_out_allowed      (audio_out_allowed),
        .write_audio_out        (write_audio_out),
        .left_channel_audio_out (left_channel_audio_out),
        .right_channel_audio_out(right_channel_audio_out),
        .overflow               (overflow),
        .clr_overflow           (clr_overflow)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // Expected codec sample: half the input, divided by 2^(15-volume), muted at 0
    function automatic logic [31:0] model_y(input logic [31:0] s, input logic [3:0] v);
        int unsigned sh;
        if (v == 4'd0) return 32'd0;
        sh = 15 - int'(v);
        return (s >> 1) / (32'd1 << sh);
    endfunction

    task automatic drive();
        int f;
        int ph;
        f  = cyc / DIV;
        ph = cyc % DIV;
        if (ph == 0)
            mode = !run1 ? int'($urandom_range(0, 2)) :
                   f <= 5 ? 2 : f <= 11 ? 0 : f == 12 ? 3 : f == 13 ? 2 :
                   f <= 23 ? int'($urandom_range(0, 2)) : 0;
        audio_out_allowed = mode == 2 ? 1'b1 : mode == 1 ? ($urandom_range(0, 63) == 0) :
                            mode == 3 ? (ph == 1) : 1'b0;
        clr_overflow = (run1 && f < 14) ? (f == 11 && ph == 600) : ($urandom_range(0, 1499) == 0);
        if (ph == 500) begin
            if (run1 && f <= 2) begin
                sample_in = 32'h0000_0200;
                volume    = 4'd15;
            end else if (run1 && f == 3) begin
                sample_in = $urandom;
                volume    = 4'd0;
            end else if (run1 && f == 4) begin
                sample_in = 32'h8000_0000;
                volume    = 4'd14;
            end else begin
                sample_in = $urandom;
                volume    = 4'($urandom_range(0, 15));
            end
        end
    endtask

    // Entered and left on a falling edge; one loop pass per clock cycle
    task automatic run(input int nframes);
        logic [31:0] y;
        while (cyc < nframes * DIV) begin
            drive();
            #1;
            exp_w = mq.size() > 0 && audio_out_allowed;
            if (write_audio_out && first_seen < 0) first_seen = cyc;
            if (exp_w || write_audio_out) check("strobe", 32'(write_audio_out), 32'(exp_w));
            if (exp_w) begin
                check("left", left_channel_audio_out, mq[0]);
                check("right", right_channel_audio_out, mq[0]);
            end else if (cyc % 97 == 0) begin
                check("left_hold", left_channel_audio_out, last_exp);
                check("right_hold", right_channel_audio_out, last_exp);
            end
            if (cyc % DIV == 2 || cyc % 97 == 0) check("overflow", 32'(overflow), 32'(ov_exp));
            @(posedge clk);
            cyc++;
            if (exp_w) last_exp = mq.pop_front();
            if (cyc >= DIV + 2 && cyc % DIV == 2) begin
                y = model_y(sample_in, volume);
                if (mq.size() < DEPTH) begin
                    mq.push_back(y);
                    if (clr_overflow) ov_exp = 1'b0;
                end else ov_exp = 1'b1;
            end else if (clr_overflow) ov_exp = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        repeat (5) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_strobe", 32'(write_audio_out), 32'd0);
        check("rst_left", left_channel_audio_out, 32'd0);
        check("rst_right", right_channel_audio_out, 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        run(26);
        check("first_write_cycle", 32'(first_seen), 32'd1043);
        audio_out_allowed = 1'b1;
        #1;
        check("pre_reset_strobe", 32'(write_audio_out), 32'(mq.size() > 0));
        #1;
        reset_n = 1'b0;
        #1;
        check("async_rst_strobe", 32'(write_audio_out), 32'd0);
        check("async_rst_left", left_channel_audio_out, 32'd0);
        check("async_rst_right", right_channel_audio_out, 32'd0);
        check("async_rst_overflow", 32'(overflow), 32'd0);
        mq.delete();
        last_exp = '0;
        ov_exp   = 1'b0;
        repeat (5) begin
            @(negedge clk);
            #1;
            check("in_rst_strobe", 32'(write_audio_out), 32'd0);
        end
        @(negedge clk);
        reset_n = 1'b1;
        cyc  = 0;
        run1 = 1'b0;
        run(15);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
